fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Controller and MAC datapath for the 64-tap, 16-bit FIR filter. Accepts one input sample per handshake and keeps the sample history in an internal ring buffer. For each sample it sequences a full sequential read of the coefficient memory, accumulates the dot product and presents one filtered output. It also arbitrates host coefficient writes against filtering so that coefficients never change mid-computation.

## Interface
Parameters:
- DATA_WIDTH, 16, sample/coefficient width (signed two's complement)
- TAPS, 64, number of taps; coefficient memory depth
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(TAPS) (=38), accumulator/output width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- coef_wr  in  1  host coefficient write request
- coef_addr  in  $clog2(TAPS)  host coefficient address
- coef_data  in  DATA_WIDTH  host coefficient value
- coef_ready  out  1  write accepted this cycle when coef_wr & coef_ready
- cload  out  1  coefficient memory write enable (registered)
- caddr  out  $clog2(TAPS)  coefficient memory write address (registered)
- cin  out  DATA_WIDTH  coefficient memory write data (registered)
- rd_en  out  1  coefficient memory read enable; memory advances its internal read counter on each rd_en
- coef_rdata  in  DATA_WIDTH  coefficient memory read data, valid one cycle after rd_en
- readco_done  in  1  memory flag, high when coefficient TAPS-1 is on coef_rdata
- din_valid  in  1  input sample valid
- din  in  DATA_WIDTH  input sample
- din_ready  out  1  sample accepted when din_valid & din_ready
- dout_valid  out  1  one-cycle pulse, dout valid
- dout  out  ACC_WIDTH  filter output y[n]
- seq_err  out  1  sticky coefficient-read desync flag

## Operation
- States: IDLE, RUN, LAST.
- IDLE:
  - coef_ready = 1.
  - din_ready = !coef_wr; a host write has priority over a sample in the same cycle.
  - Accepted write: cload/caddr/cin register coef_wr/coef_addr/coef_data next cycle. cload = 0 otherwise.
  - Accepted sample: write din at wr_ptr+1 (mod TAPS), which becomes the new wr_ptr. Clear acc and k. Go to RUN.
- RUN (TAPS cycles):
  - rd_en = 1, coef_ready = 0, din_ready = 0.
  - k counts 0..TAPS-1. Register x[n-k] = hist[(wr_ptr-k) mod TAPS] alongside rd_en so it aligns with coef_rdata one cycle later.
  - From the second RUN cycle onward: acc += sext(coef_rdata * x_reg), signed DATA_WIDTH×DATA_WIDTH product sign-extended to ACC_WIDTH.
  - After k = TAPS-1, go to LAST.
- LAST (1 cycle):
  - rd_en = 0. Accumulate the final product (coefficient TAPS-1).
  - If readco_done = 0 in this cycle, set seq_err. seq_err clears only on rst.
  - Register dout = final sum, dout_valid = 1 next cycle. Go to IDLE.
- Coefficient writes presented outside IDLE are held off (coef_ready = 0); the host holds coef_wr until accepted.
- Arithmetic: exact, no overflow possible at ACC_WIDTH; no rounding or saturation.
- Sample history (TAPS × DATA_WIDTH) resets to zero, so the first TAPS outputs see zero-padded history.
- dout holds its value until the next result.

## Timing
- Reset values: coef_ready 0 during rst, then 1 in IDLE; din_ready 0 during rst; cload 0, caddr 0, cin 0, rd_en 0, dout_valid 0, dout 0, seq_err 0. State IDLE, wr_ptr = TAPS-1, history, acc and k all 0.
- Sample accepted at edge E0:
  - RUN covers cycles 1..TAPS, with rd_en high for exactly TAPS consecutive cycles.
  - LAST is cycle TAPS+1.
  - dout_valid is high in cycle TAPS+2 (66). IDLE is entered in the same cycle, so din_ready may be high in cycle 66.
  - Maximum throughput: one sample per TAPS+2 cycles.
- Coefficient write accepted at edge E: cload is high in cycle E+1 only.
- rst asserted mid-RUN/LAST: next state IDLE, no dout_valid, history and acc cleared. The coefficient memory must be reset in the same cycle to realign its read counter.

## Test plan
- Reset: hold rst 3 cycles -> all outputs at reset values; coef_ready = 1 and din_ready = 1 the cycle after release.
- Impulse: load c[k] = k+1 for k = 0..63, feed 1 then 63 zeros -> dout sequence 1, 2, …, 64, each pulse exactly 66 cycles after its accept edge; rd_en high for 64 cycles per sample.
- Extremes: all c = 0x7FFF, 64 samples of 0x8000 -> 64th dout = -68,717,379,584 (38-bit signed), no wrap.
- Arbitration: coef_wr and din_valid both high in IDLE -> write accepted, din_ready = 0 that cycle, sample accepted next cycle. coef_wr raised during RUN -> coef_ready = 0 and no cload until IDLE.
- Desync: model returns readco_done = 0 in LAST -> seq_err = 1 and stays 1 until rst; dout still produced.
- Reset mid-RUN (cycle 30) -> no dout_valid. The next impulse with c[k] = k+1 yields dout = 1, proving history was cleared.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Sequential FIR engine: one full coefficient-memory pass per accepted sample,
// MAC against a ring-buffered sample history, with host coefficient writes gated to IDLE.
module fir_mac_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int TAPS       = 64,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(TAPS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        coef_wr,
   input  logic [$clog2(TAPS)-1:0]     coef_addr,
   input  logic [DATA_WIDTH-1:0]       coef_data,
   output logic                        coef_ready,
   output logic                        cload,
   output logic [$clog2(TAPS)-1:0]     caddr,
   output logic [DATA_WIDTH-1:0]       cin,
   output logic                        rd_en,
   input  logic [DATA_WIDTH-1:0]       coef_rdata,
   input  logic                        readco_done,
   input  logic                        din_valid,
   input  logic [DATA_WIDTH-1:0]       din,
   output logic                        din_ready,
   output logic                        dout_valid,
   output logic signed [ACC_WIDTH-1:0] dout,
   output logic                        seq_err
);
   localparam int AW = $clog2(TAPS);
   localparam logic [AW-1:0] K_LAST = AW'(TAPS-1);

   typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
   state_t state, state_nxt;

   logic signed [DATA_WIDTH-1:0] hist [TAPS];
   logic [AW-1:0]                wr_ptr, wr_ptr_nxt, rd_idx, k;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [DATA_WIDTH-1:0] x_p1;
   logic                         vld_p1;
   logic signed [ACC_WIDTH-1:0]  prod_p1;
   logic                         wr_acc, din_acc;

   // Full-precision signed product, sign-extended to the accumulator width.
   function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      logic signed [2*DATA_WIDTH-1:0] a_w, b_w, p;
      a_w = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
      b_w = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
      p   = a_w * b_w;
      return {{(ACC_WIDTH-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
   endfunction

   assign wr_acc     = coef_wr & coef_ready;
   assign din_acc    = din_valid & din_ready;
   assign wr_ptr_nxt = wr_ptr + 1'b1;
   assign rd_idx     = wr_ptr - k;
   assign prod_p1    = sext_prod($signed(coef_rdata), x_p1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      coef_ready = 1'b0;
      din_ready  = 1'b0;
      rd_en      = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               coef_ready = 1'b1;
               din_ready  = !coef_wr;
               if (din_valid && !coef_wr) state_nxt = RUN;
            end
            RUN: begin
               rd_en = 1'b1;
               if (k == K_LAST) state_nxt = LAST;
            end
            LAST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= K_LAST;
         k          <= '0;
         vld_p1     <= 1'b0;
         cload      <= 1'b0;
         caddr      <= '0;
         cin        <= '0;
         dout_valid <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         cload <= wr_acc;
         if (wr_acc) begin
            caddr <= coef_addr;
            cin   <= coef_data;
         end
         if (din_acc) begin
            wr_ptr <= wr_ptr_nxt;
            k      <= '0;
         end else if (state == RUN) begin
            k <= k + 1'b1;
         end
         vld_p1     <= rd_en;
         dout_valid <= (state == LAST);
         if (state == LAST && !readco_done) seq_err <= 1'b1;
      end
   end

   // p0 -> p1: sample x[n-k] registered with rd_en so it meets coef_rdata next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) hist[i] <= '0;
         acc  <= '0;
         x_p1 <= '0;
         dout <= '0;
      end else begin
         if (din_acc) begin
            hist[wr_ptr_nxt] <= din;
            acc              <= '0;
         end
         if (rd_en) x_p1 <= hist[rd_idx];
         // p1 -> acc: the last product is folded straight into dout in LAST.
         if (vld_p1 && state == RUN) acc <= acc + prod_p1;
         if (state == LAST) dout <= acc + prod_p1;
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: behavioural coefficient memory plus a dot-product
// reference over a queue of accepted samples.
module tb_fir_mac_sequencer;
   localparam int DW   = 16;
   localparam int TAPS = 64;
   localparam int AW   = 6;
   localparam int ACCW = 38;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   coef_wr;
   logic [AW-1:0]          coef_addr;
   logic [DW-1:0]          coef_data;
   logic                   coef_ready;
   logic                   cload;
   logic [AW-1:0]          caddr;
   logic [DW-1:0]          cin;
   logic                   rd_en;
   logic [DW-1:0]          coef_rdata;
   logic                   readco_done;
   logic                   din_valid;
   logic [DW-1:0]          din;
   logic                   din_ready;
   logic                   dout_valid;
   logic signed [ACCW-1:0] dout;
   logic                   seq_err;

   logic [DW-1:0] cmem [TAPS];
   logic [AW-1:0] rcnt;
   logic          done_r;
   logic          desync;

   longint c_model [TAPS];
   longint hist_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   fir_mac_sequencer #(.DATA_WIDTH(DW), .TAPS(TAPS), .ACC_WIDTH(ACCW)) dut (
      .clk(clk), .rst(rst),
      .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready),
      .cload(cload), .caddr(caddr), .cin(cin),
      .rd_en(rd_en), .coef_rdata(coef_rdata), .readco_done(readco_done),
      .din_valid(din_valid), .din(din), .din_ready(din_ready),
      .dout_valid(dout_valid), .dout(dout), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   // Coefficient memory: write port from cload, sequential read counter realigned by rst.
   always @(posedge clk) begin
      if (cload) cmem[caddr] <= cin;
      if (rst) begin
         rcnt   <= '0;
         done_r <= 1'b0;
      end else if (rd_en) begin
         coef_rdata <= cmem[rcnt];
         done_r     <= (rcnt == AW'(TAPS-1));
         rcnt       <= rcnt + 1'b1;
      end
   end
   assign readco_done = done_r & ~desync;

   function automatic longint model_out();
      longint s = 0;
      for (int j = 0; j < TAPS; j++)
         if (j < int'(hist_q.size())) s += c_model[j] * hist_q[j];
      return s;
   endfunction

   function automatic void model_push(input longint x);
      hist_q.push_front(x);
      if (hist_q.size() > TAPS) void'(hist_q.pop_back());
   endfunction

   task automatic write_coef(input int a, input logic signed [DW-1:0] d);
      int guard;
      @(posedge clk); #1;
      coef_wr = 1'b1; coef_addr = AW'(a); coef_data = d;
      guard = 0;
      @(negedge clk);
      while (!coef_ready && guard < 200) begin @(negedge clk); guard++; end
      n_checks++;
      if (!coef_ready) begin
         n_fail++;
         $display("FAIL write_timeout: coef_ready=%0b after %0d cycles, required 1", coef_ready, guard);
      end
      @(posedge clk); #1;
      coef_wr = 1'b0;
      c_model[a] = longint'(d);
   endtask

   task automatic load_ramp();
      for (int j = 0; j < TAPS; j++) write_coef(j, DW'(j + 1));
   endtask

   task automatic do_sample(input logic signed [DW-1:0] s, output longint got, output longint want,
                            output int lat, output int rdc, output logic rdy_out);
      int guard;
      logic seen;
      @(posedge clk); #1;
      din_valid = 1'b1; din = s;
      guard = 0;
      @(negedge clk);
      while (!din_ready && guard < 200) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      din_valid = 1'b0;
      model_push(longint'(s));
      want = model_out();
      lat = 0; rdc = 0; got = 0; rdy_out = 1'b0; seen = 1'b0;
      for (int i = 1; i <= 200 && !seen; i++) begin
         @(negedge clk);
         if (rd_en) rdc++;
         if (dout_valid) begin
            seen = 1'b1; lat = i; got = dout; rdy_out = din_ready;
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL sample_timeout: dout_valid=0 for 200 cycles, required a pulse");
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL rst_coef_ready: got %0b want 0", coef_ready); end
      n_checks++; if (din_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_din_ready: got %0b want 0", din_ready); end
      n_checks++; if (cload !== 1'b0)      begin n_fail++; $display("FAIL rst_cload: got %0b want 0", cload); end
      n_checks++; if (caddr !== '0)        begin n_fail++; $display("FAIL rst_caddr: got %0d want 0", caddr); end
      n_checks++; if (cin !== '0)          begin n_fail++; $display("FAIL rst_cin: got %0d want 0", cin); end
      n_checks++; if (rd_en !== 1'b0)      begin n_fail++; $display("FAIL rst_rd_en: got %0b want 0", rd_en); end
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid: got %0b want 0", dout_valid); end
      n_checks++; if (dout !== '0)         begin n_fail++; $display("FAIL rst_dout: got %0d want 0", dout); end
      n_checks++; if (seq_err !== 1'b0)    begin n_fail++; $display("FAIL rst_seq_err: got %0b want 0", seq_err); end
      @(posedge clk); #1;
      rst = 1'b0;
      hist_q.delete();
      @(negedge clk);
      n_checks++; if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_coef_ready: got %0b want 1", coef_ready); end
      n_checks++; if (din_ready !== 1'b1)  begin n_fail++; $display("FAIL post_rst_din_ready: got %0b want 1", din_ready); end
   endtask

   task automatic test_impulse();
      longint got, want;
      int lat, rdc;
      logic rdy;
      load_ramp();
      for (int i = 0; i < TAPS; i++) begin
         do_sample((i == 0) ? 16'sd1 : 16'sd0, got, want, lat, rdc, rdy);
         n_checks++; if (got !== want) begin n_fail++; $display("FAIL imp_model[%0d]: got %0d want %0d", i, got, want); end
         n_checks++; if (got !== longint'(i + 1)) begin n_fail++; $display("FAIL imp_value[%0d]: got %0d want %0d", i, got, i + 1); end
         n_checks++; if (lat != TAPS + 2) begin n_fail++; $display("FAIL imp_latency[%0d]: got %0d want %0d", i, lat, TAPS + 2); end
         n_checks++; if (rdc != TAPS) begin n_fail++; $display("FAIL imp_rd_en_cycles[%0d]: got %0d want %0d", i, rdc, TAPS); end
         n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL imp_din_ready_at_out[%0d]: got %0b want 1", i, rdy); end
      end
   endtask

   task automatic test_arbitration();
      logic signed [DW-1:0] s, d1, d2;
      longint got, want;
      logic seen, bad;
      s  = DW'($urandom_range(1, 1000));
      d1 = DW'($urandom);
      d2 = DW'($urandom);
      got = 0;
      @(posedge clk); #1;
      coef_wr = 1'b1; coef_addr = 6'd5; coef_data = d1;
      din_valid = 1'b1; din = s;
      @(negedge clk);
      n_checks++; if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL arb_coef_ready: got %0b want 1", coef_ready); end
      n_checks++; if (din_ready !== 1'b0)  begin n_fail++; $display("FAIL arb_din_ready_blocked: got %0b want 0", din_ready); end
      @(posedge clk); #1;
      coef_wr = 1'b0;
      c_model[5] = longint'(d1);
      @(negedge clk);
      n_checks++; if (cload !== 1'b1) begin n_fail++; $display("FAIL arb_cload: got %0b want 1", cload); end
      n_checks++; if (caddr !== 6'd5) begin n_fail++; $display("FAIL arb_caddr: got %0d want 5", caddr); end
      n_checks++; if (cin !== d1)     begin n_fail++; $display("FAIL arb_cin: got %0h want %0h", cin, d1); end
      n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL arb_din_ready_next: got %0b want 1", din_ready); end
      @(posedge clk); #1;
      din_valid = 1'b0;
      model_push(longint'(s));
      want = model_out();
      coef_wr = 1'b1; coef_addr = 6'd7; coef_data = d2;
      seen = 1'b0; bad = 1'b0;
      for (int i = 1; i <= 200 && !seen; i++) begin
         @(negedge clk);
         if (dout_valid) begin seen = 1'b1; got = dout; end
         else if (coef_ready || cload) bad = 1'b1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL arb_dout_timeout: dout_valid=0, required a pulse"); end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL arb_holdoff: coef_ready/cload seen high=%0b, required 0", bad); end
      n_checks++; if (got !== want) begin n_fail++; $display("FAIL arb_dout: got %0d want %0d", got, want); end
      n_checks++; if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL arb_ready_in_idle: got %0b want 1", coef_ready); end
      @(posedge clk); #1;
      coef_wr = 1'b0;
      c_model[7] = longint'(d2);
      @(negedge clk);
      n_checks++; if (cload !== 1'b1 || caddr !== 6'd7 || cin !== d2) begin
         n_fail++; $display("FAIL arb_late_write: got cload=%0b caddr=%0d cin=%0h want 1/7/%0h", cload, caddr, cin, d2);
      end
      @(negedge clk);
      n_checks++; if (cload !== 1'b0) begin n_fail++; $display("FAIL arb_cload_one_cycle: got %0b want 0", cload); end
   endtask

   task automatic test_desync();
      longint got, want;
      int lat, rdc;
      logic rdy;
      n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL desync_pre: got seq_err=%0b want 0", seq_err); end
      desync = 1'b1;
      do_sample(DW'($urandom), got, want, lat, rdc, rdy);
      desync = 1'b0;
      n_checks++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL desync_set: got seq_err=%0b want 1", seq_err); end
      n_checks++; if (got !== want) begin n_fail++; $display("FAIL desync_dout: got %0d want %0d", got, want); end
      do_sample(DW'($urandom), got, want, lat, rdc, rdy);
      n_checks++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL desync_sticky: got seq_err=%0b want 1", seq_err); end
      n_checks++; if (got !== want) begin n_fail++; $display("FAIL desync_dout2: got %0d want %0d", got, want); end
   endtask

   task automatic test_back_to_back();
      logic signed [DW-1:0] xs [3];
      longint expq [$];
      int acc_cyc [$];
      int cyc, nacc, ndone;
      longint want;
      for (int j = 0; j < 3; j++) xs[j] = DW'($urandom);
      @(posedge clk); #1;
      din_valid = 1'b1; din = xs[0];
      cyc = 0; nacc = 0; ndone = 0;
      while (ndone < 3 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (dout_valid) begin
            want = (expq.size() > 0) ? expq.pop_front() : 64'd0;
            n_checks++; if (dout !== want[ACCW-1:0]) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %0d want %0d", ndone, dout, want); end
            ndone++;
         end
         if (din_valid && din_ready) begin
            acc_cyc.push_back(cyc);
            nacc++;
            @(posedge clk); #1;
            model_push(longint'(xs[nacc-1]));
            expq.push_back(model_out());
            if (nacc < 3) din = xs[nacc];
            else din_valid = 1'b0;
         end
      end
      din_valid = 1'b0;
      n_checks++; if (ndone != 3) begin n_fail++; $display("FAIL b2b_count: got %0d outputs want 3", ndone); end
      n_checks++; if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != TAPS + 2 || acc_cyc[2] - acc_cyc[1] != TAPS + 2) begin
         n_fail++; $display("FAIL b2b_interval: got %0d accepts, want 3 spaced %0d cycles", acc_cyc.size(), TAPS + 2);
      end
   endtask

   task automatic test_random();
      longint got, want;
      int lat, rdc;
      logic rdy;
      for (int j = 0; j < TAPS; j++) write_coef(j, DW'($urandom));
      for (int i = 0; i < 40; i++) begin
         do_sample(DW'($urandom), got, want, lat, rdc, rdy);
         n_checks++; if (got !== want) begin n_fail++; $display("FAIL rand_dout[%0d]: got %0d want %0d", i, got, want); end
         n_checks++; if (lat != TAPS + 2) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, TAPS + 2); end
      end
   endtask

   task automatic test_extremes();
      longint got, want;
      int lat, rdc;
      logic rdy;
      for (int j = 0; j < TAPS; j++) write_coef(j, 16'sh7FFF);
      got = 0;
      for (int i = 0; i < TAPS; i++) begin
         do_sample(16'sh8000, got, want, lat, rdc, rdy);
         n_checks++; if (got !== want) begin n_fail++; $display("FAIL ext_dout[%0d]: got %0d want %0d", i, got, want); end
      end
      n_checks++; if (got !== -64'sd68717379584) begin n_fail++; $display("FAIL ext_final: got %0d want -68717379584", got); end
      @(negedge clk);
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ext_pulse_width: got dout_valid=%0b want 0", dout_valid); end
      n_checks++; if (longint'(dout) !== got) begin n_fail++; $display("FAIL ext_hold: got %0d want %0d", dout, got); end
   endtask

   task automatic test_reset_mid_run();
      longint got, want;
      int lat, rdc, guard;
      logic rdy, bad;
      load_ramp();
      @(posedge clk); #1;
      din_valid = 1'b1; din = DW'($urandom_range(1, 30000));
      guard = 0;
      @(negedge clk);
      while (!din_ready && guard < 200) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      din_valid = 1'b0;
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      hist_q.delete();
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dout_valid) bad = 1'b1;
      end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL midrst_no_dout: dout_valid seen=%0b want 0", bad); end
      n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL midrst_dout_cleared: got %0d want 0", dout); end
      n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL midrst_seq_err: got %0b want 0", seq_err); end
      do_sample(16'sd1, got, want, lat, rdc, rdy);
      n_checks++; if (got !== 64'sd1) begin n_fail++; $display("FAIL midrst_impulse: got %0d want 1", got); end
      n_checks++; if (got !== want) begin n_fail++; $display("FAIL midrst_model: got %0d want %0d", got, want); end
      n_checks++; if (rdc != TAPS) begin n_fail++; $display("FAIL midrst_rd_en_cycles: got %0d want %0d", rdc, TAPS); end
   endtask

   initial begin
      rst = 1'b1;
      coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
      din_valid = 1'b0; din = '0;
      desync = 1'b0;
      test_reset();
      test_impulse();
      test_arbitration();
      test_desync();
      test_back_to_back();
      test_random();
      test_extremes();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
